// File: rtl/apb_regs_mixed.sv
// ---------------------------------------------------------------------------
// apb_regs_mixed
//   APB slave register file with a per-register access mode, byte strobes,
//   a fixed number of wait states and an error response on illegal accesses.
//   Sits between an APB demux port and peripheral control/status logic.
//
// Ports
//   pclk_i       clock
//   preset_ni    synchronous reset, active low
//   paddr_i      APB address
//   psel_i       APB select
//   penable_i    APB enable
//   pwrite_i     1 = write, 0 = read
//   pwdata_i     write data
//   pstrb_i      byte strobes for writes
//   pready_o     transfer complete (combinational from state)
//   prdata_o     read data, non-zero only in the pready cycle of a good read
//   pslverr_o    error response, only in the pready cycle
//   base_addr_i  base address of register 0, 4-byte aligned
//   reg_init_i   per-register reset values
//   reg_d_i      per-register HW value (RO read / W1C set / RWHW load)
//   hw_set_i     per-register HW strobe (W1C set, RWHW load)
//   reg_q_o      register contents
//   reg_wr_o     one-cycle pulse, the cycle after a committed SW write
// ---------------------------------------------------------------------------
module apb_regs_mixed #(
    parameter int unsigned NoApbRegs    = 16,
    parameter int unsigned ApbAddrWidth = 32,
    parameter int unsigned ApbDataWidth = 32,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned WaitCycles   = 0,
    parameter logic [NoApbRegs-1:0][1:0] RegMode = {NoApbRegs{2'b01}}
) (
    input  logic                                      pclk_i,
    input  logic                                      preset_ni,
    input  logic [ApbAddrWidth-1:0]                   paddr_i,
    input  logic                                      psel_i,
    input  logic                                      penable_i,
    input  logic                                      pwrite_i,
    input  logic [ApbDataWidth-1:0]                   pwdata_i,
    input  logic [ApbDataWidth/8-1:0]                 pstrb_i,
    output logic                                      pready_o,
    output logic [ApbDataWidth-1:0]                   prdata_o,
    output logic                                      pslverr_o,
    input  logic [ApbAddrWidth-1:0]                   base_addr_i,
    input  logic [NoApbRegs-1:0][RegDataWidth-1:0]    reg_init_i,
    input  logic [NoApbRegs-1:0][RegDataWidth-1:0]    reg_d_i,
    input  logic [NoApbRegs-1:0]                      hw_set_i,
    output logic [NoApbRegs-1:0][RegDataWidth-1:0]    reg_q_o,
    output logic [NoApbRegs-1:0]                      reg_wr_o
);

    localparam logic [1:0] ModeRo   = 2'd0;
    localparam logic [1:0] ModeRw   = 2'd1;
    localparam logic [1:0] ModeW1c  = 2'd2;
    localparam logic [1:0] ModeRwhw = 2'd3;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                                   state_q, state_d;
    logic [3:0]                               cnt_q, cnt_d;
    // Full-width word offset so out-of-range (and below-base) addresses
    // are detectable rather than aliased onto a valid register.
    logic [ApbAddrWidth-1:0]                  idx_q, idx_d;
    logic                                     write_q, write_d;
    logic [NoApbRegs-1:0][RegDataWidth-1:0]   reg_q_q, reg_q_d;
    logic [NoApbRegs-1:0]                     reg_wr_q, reg_wr_d;

    logic [NoApbRegs-1:0]                     sel;
    logic [1:0]                               sel_mode;
    logic [RegDataWidth-1:0]                  rd_data;
    logic                                     done;
    logic                                     err;
    logic [NoApbRegs-1:0]                     sw_we;
    logic [RegDataWidth-1:0]                  wr_mask;
    logic [RegDataWidth-1:0]                  wr_data;

    // Expand byte strobes to a bit mask over the register width.
    function automatic logic [RegDataWidth-1:0] strb_mask(
        input logic [ApbDataWidth/8-1:0] strb
    );
        logic [RegDataWidth-1:0] m;
        for (int k = 0; k < int'(RegDataWidth); k++) begin
            m[k] = strb[k/8];
        end
        return m;
    endfunction

    // Decode of the latched index and response generation.
    always_comb begin
        sel      = '0;
        sel_mode = ModeRw;
        rd_data  = '0;
        for (int i = 0; i < int'(NoApbRegs); i++) begin
            if (idx_q == ApbAddrWidth'(i)) begin
                sel[i]   = 1'b1;
                sel_mode = RegMode[i];
                rd_data  = (RegMode[i] == ModeRo) ? reg_d_i[i] : reg_q_q[i];
            end
        end
        err       = (sel == '0) || (write_q && (sel_mode == ModeRo));
        done      = (state_q == ACCESS) && psel_i && penable_i && (cnt_q == 4'd0);
        pready_o  = done;
        pslverr_o = done && err;
        prdata_o  = (done && !err && !write_q) ? ApbDataWidth'(rd_data) : '0;
        sw_we     = (done && !err && write_q) ? sel : '0;
    end

    // Transfer FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        unique case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WaitCycles);
                    idx_d   = (paddr_i - base_addr_i) >> 2;
                    write_d = pwrite_i;
                end
            end
            ACCESS: begin
                if (psel_i && penable_i) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Master dropped the transfer: abort without response.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register next state: SW commit merged with HW set/load.
    always_comb begin
        reg_q_d  = reg_q_q;
        reg_wr_d = sw_we;
        wr_mask  = strb_mask(pstrb_i);
        wr_data  = pwdata_i[RegDataWidth-1:0];
        for (int i = 0; i < int'(NoApbRegs); i++) begin
            unique case (RegMode[i])
                ModeRw: begin
                    if (sw_we[i]) begin
                        reg_q_d[i] = (reg_q_q[i] & ~wr_mask) | (wr_data & wr_mask);
                    end
                end
                ModeW1c: begin
                    // Clear first, then OR in the HW set so a set wins per bit.
                    if (sw_we[i]) begin
                        reg_q_d[i] = reg_q_q[i] & ~(wr_data & wr_mask);
                    end
                    if (hw_set_i[i]) begin
                        reg_q_d[i] = reg_q_d[i] | reg_d_i[i];
                    end
                end
                ModeRwhw: begin
                    // HW load first, then SW overrides only the strobed bytes.
                    if (hw_set_i[i]) begin
                        reg_q_d[i] = reg_d_i[i];
                    end
                    if (sw_we[i]) begin
                        reg_q_d[i] = (reg_q_d[i] & ~wr_mask) | (wr_data & wr_mask);
                    end
                end
                default: reg_q_d[i] = reg_q_q[i];
            endcase
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!preset_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            reg_q_q  <= reg_init_i;
            reg_wr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            reg_q_q  <= reg_q_d;
            reg_wr_q <= reg_wr_d;
        end
    end

    assign reg_q_o  = reg_q_q;
    assign reg_wr_o = reg_wr_q;

endmodule
